fb_readback: RTL and testbench

FB_READBACK -- requirements
Module: fb_readback

---
 rtl/fb_readback_pkg.sv | 49 ++++
 rtl/fb_readback.sv | 117 +++++++++++
 tb/tb_fb_readback.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_readback_pkg.sv
// Shared raytracer definitions used by the framebuffer readback path:
// frame geometry, dump header bytes and the readback FSM encoding.
package fb_readback_pkg;

   // Native framebuffer geometry (640x480, one 24-bit pixel per address).
   localparam int FRAME_W      = 640;
   localparam int FRAME_H      = 480;
   localparam int FRAME_PIXELS = FRAME_W * FRAME_H;

   // Two-byte sync header that precedes every dump so the host can align.
   localparam logic [7:0] HDR0_BYTE = 8'hA5;
   localparam logic [7:0] HDR1_BYTE = 8'h5A;

   // Readback FSM states. IDLE is zero so the reset state decodes to
   // all-quiet outputs.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR0    = 3'd1,
      ST_HDR1    = 3'd2,
      ST_FETCH   = 3'd3,
      ST_CAPTURE = 3'd4,
      ST_SEND_R  = 3'd5,
      ST_SEND_G  = 3'd6,
      ST_SEND_B  = 3'd7
   } fb_state_e;

   // True in the states that present a byte to the transmitter.
   function automatic logic is_tx_state(input fb_state_e s);
      return (s == ST_HDR0) || (s == ST_HDR1) ||
             (s == ST_SEND_R) || (s == ST_SEND_G) || (s == ST_SEND_B);
   endfunction

   // Byte presented in each transmitting state; zero everywhere else so
   // tx_data reads 0x00 whenever tx_valid is low (including reset).
   function automatic logic [7:0] tx_byte(input fb_state_e s, input logic [23:0] px);
      logic [7:0] b;
      b = 8'h00;
      case (s)
         ST_HDR0:   b = HDR0_BYTE;
         ST_HDR1:   b = HDR1_BYTE;
         ST_SEND_R: b = px[23:16];
         ST_SEND_G: b = px[15:8];
         ST_SEND_B: b = px[7:0];
         default:   b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fb_readback.sv
// Framebuffer readback: streams a 2-byte header then every pixel as R,G,B
// bytes to a UART transmitter using a valid/ready handshake.
// All byte-facing outputs decode directly from registered state, so they
// hold steady across transmitter stalls and drop to zero on reset.
module fb_readback
   import fb_readback_pkg::*;
#(
   parameter int NUM_PIXELS = FRAME_PIXELS,
   parameter int ADDR_W     = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              fb_rd_en,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [23:0]       fb_data,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   // Address of the final pixel; the counter stops here and never wraps.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [23:0]       pixel_q, pixel_d;
   logic              done_q,  done_d;
   logic              tx_fire;

   // Output decode from registered state (no combinational path from inputs).
   always_comb begin
      tx_valid = is_tx_state(state_q);
      tx_data  = tx_byte(state_q, pixel_q);
      fb_rd_en = (state_q == ST_FETCH);
   end

   assign tx_fire = tx_valid && tx_ready;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign fb_addr = count_q;

   // Next-state logic: abort overrides everything outside IDLE.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pixel_d = pixel_q;
      done_d  = 1'b0;

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // abort in the same cycle as start suppresses the request
               if (start && !abort) begin
                  state_d = ST_HDR0;
                  count_d = '0;
               end
            end
            ST_HDR0: begin
               if (tx_fire) state_d = ST_HDR1;
            end
            ST_HDR1: begin
               if (tx_fire) state_d = ST_FETCH;
            end
            ST_FETCH: begin
               // single-cycle read strobe; data returns next cycle
               state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               pixel_d = fb_data;
               state_d = ST_SEND_R;
            end
            ST_SEND_R: begin
               if (tx_fire) state_d = ST_SEND_G;
            end
            ST_SEND_G: begin
               if (tx_fire) state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
               if (tx_fire) begin
                  if (count_q == LAST_ADDR) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     count_d = count_q + ADDR_W'(1);
                     state_d = ST_FETCH;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, counter, pixel and done registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         pixel_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pixel_q <= pixel_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_fb_readback.sv
// Directed bench for fb_readback with a 4-pixel frame. A small framebuffer
// model answers reads one cycle later; a monitor records accepted bytes,
// read strobes, done pulses and stall stability for the directed checks.
module tb_fb_readback;

   localparam int NPIX = 4;
   localparam int AW   = 19;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          start    = 1'b0;
   logic          abort    = 1'b0;
   logic          tx_ready = 1'b1;
   logic [23:0]   fb_data  = '0;
   logic          busy;
   logic          done;
   logic          fb_rd_en;
   logic [AW-1:0] fb_addr;
   logic [7:0]    tx_data;
   logic          tx_valid;

   int checks = 0;
   int errors = 0;

   // monitor state
   int         cyc       = 0;
   int         rd_cnt    = 0;
   int         done_cnt  = 0;
   int         done_cyc  = 0;
   int         hdr_cnt   = 0;
   int         hdr_cyc   = 0;
   int         stall_cnt = 0;
   int         stall_err = 0;
   logic       busy_prev = 1'b0;
   logic       stall_prev = 1'b0;
   logic [7:0] stall_data = 8'h00;
   logic [7:0] got[$];

   logic [7:0] exp_bytes [14] = '{8'hA5, 8'h5A,
                                  8'h00, 8'h02, 8'h00,
                                  8'h10, 8'h02, 8'h01,
                                  8'h20, 8'h02, 8'h02,
                                  8'h30, 8'h02, 8'h03};

   always #5 clk = ~clk;

   fb_readback #(.NUM_PIXELS(NPIX), .ADDR_W(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .fb_rd_en (fb_rd_en),
      .fb_addr  (fb_addr),
      .fb_data  (fb_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   function automatic logic [23:0] fb_word(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'h0010_0000 * 32'(a) + 32'h0000_0200 + 32'(a);
      return w[23:0];
   endfunction

   // framebuffer model: data valid the cycle after the read strobe
   always @(posedge clk) begin
      if (fb_rd_en) fb_data <= fb_word(fb_addr);
   end

   // monitor: samples pre-edge values at every rising edge
   always @(posedge clk) begin
      cyc++;
      if (stall_prev && (!tx_valid || tx_data !== stall_data)) stall_err++;
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
      if (stall_prev) stall_cnt++;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (fb_rd_en) rd_cnt++;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy && !busy_prev) begin
         hdr_cnt++;
         hdr_cyc = cyc;
      end
      busy_prev = busy;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got.delete();
      rd_cnt     = 0;
      done_cnt   = 0;
      hdr_cnt    = 0;
      stall_cnt  = 0;
      stall_err  = 0;
      stall_prev = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   // wait for a done pulse, optionally throttling tx_ready to 1-of-3 cycles
   task automatic run_to_done(input string tag, input bit bp, input int budget);
      int n;
      int phase;
      n = 0;
      phase = 0;
      while (done_cnt == 0 && n < budget) begin
         if (bp) begin
            tx_ready = (phase == 0);
            phase = (phase + 1) % 3;
         end
         @(negedge clk);
         n++;
      end
      tx_ready = 1'b1;
      check({tag, "_done_seen"}, (done_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic check_seq(input string tag);
      check({tag, "_len"}, got.size(), 32'd14);
      for (int i = 0; i < 14; i++) begin
         check($sformatf("%s_byte%0d", tag, i),
               (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF,
               {24'd0, exp_bytes[i]});
      end
   endtask

   initial begin
      int n;

      // ---- asynchronous reset values ----
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy",     busy,     1'b0);
      check("rst_done",     done,     1'b0);
      check("rst_fb_rd_en", fb_rd_en, 1'b0);
      check("rst_fb_addr",  fb_addr,  '0);
      check("rst_tx_valid", tx_valid, 1'b0);
      check("rst_tx_data",  tx_data,  8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- full dump, tx_ready held high ----
      clear_mon();
      pulse_start();
      check("t1_busy_in_hdr", busy, 1'b1);
      check("t1_hdr0_byte",   tx_data, 8'hA5);
      run_to_done("t1", 1'b0, 200);
      repeat (3) @(negedge clk);
      check_seq("t1");
      check("t1_done_count", done_cnt, 32'd1);
      check("t1_latency",    done_cyc - hdr_cyc, 32'd22);
      check("t1_rd_pulses",  rd_cnt, 32'd4);
      check("t1_busy_after", busy, 1'b0);
      check("t1_addr_hold",  fb_addr, 19'd3);
      check("t1_txv_after",  tx_valid, 1'b0);

      // ---- backpressure ----
      clear_mon();
      pulse_start();
      run_to_done("t2", 1'b1, 400);
      repeat (3) @(negedge clk);
      check_seq("t2");
      check("t2_stall_stable", stall_err, 32'd0);
      check("t2_stalls_seen",  (stall_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
      check("t2_rd_pulses",    rd_cnt, 32'd4);
      check("t2_done_count",   done_cnt, 32'd1);

      // ---- abort during SEND_G of pixel 2 ----
      clear_mon();
      pulse_start();
      n = 0;
      while (got.size() < 9 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t3_reach_g2",   got.size(), 32'd9);
      check("t3_g2_valid",   tx_valid, 1'b1);
      check("t3_g2_data",    tx_data, 8'h02);
      abort = 1'b1;
      tx_ready = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      tx_ready = 1'b1;
      check("t3_busy_abort", busy, 1'b0);
      check("t3_txv_abort",  tx_valid, 1'b0);
      check("t3_rd_abort",   fb_rd_en, 1'b0);
      repeat (30) @(negedge clk);
      check("t3_no_done",    done_cnt, 32'd0);
      check("t3_no_bytes",   got.size(), 32'd9);
      clear_mon();
      pulse_start();
      run_to_done("t3r", 1'b0, 200);
      repeat (3) @(negedge clk);
      check_seq("t3r");
      check("t3r_done_count", done_cnt, 32'd1);

      // ---- start re-pulsed while busy ----
      clear_mon();
      pulse_start();
      repeat (4) @(negedge clk);
      pulse_start();
      repeat (6) @(negedge clk);
      pulse_start();
      run_to_done("t4", 1'b0, 200);
      repeat (5) @(negedge clk);
      check_seq("t4");
      check("t4_done_count", done_cnt, 32'd1);
      check("t4_hdr_count",  hdr_cnt, 32'd1);
      check("t4_busy_after", busy, 1'b0);

      // ---- reset asserted during CAPTURE of pixel 1 ----
      clear_mon();
      pulse_start();
      n = 0;
      while (rd_cnt < 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t5_in_capture_addr", fb_addr, 19'd1);
      check("t5_in_capture_busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("t5_busy",     busy,     1'b0);
      check("t5_done",     done,     1'b0);
      check("t5_fb_rd_en", fb_rd_en, 1'b0);
      check("t5_fb_addr",  fb_addr,  '0);
      check("t5_tx_valid", tx_valid, 1'b0);
      check("t5_tx_data",  tx_data,  8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t5_busy_after", busy, 1'b0);
      check("t5_txv_after",  tx_valid, 1'b0);
      check("t5_no_done",    done_cnt, 32'd0);

      // ---- start and abort together in IDLE ----
      clear_mon();
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("t6_busy", busy, 1'b0);
      check("t6_txv",  tx_valid, 1'b0);
      repeat (3) @(negedge clk);
      check("t6_no_hdr",   hdr_cnt, 32'd0);
      check("t6_no_bytes", got.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
